// File: rtl/idct_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idct_pkg
// Purpose  : Constants and helpers for the 8-point integer IDCT, shared by the
//            row pass and the later column pass.
// Revision : 1.0 - initial release
// ============================================================================
package idct_pkg;

    // All internal datapath arithmetic is 32-bit signed.
    typedef logic signed [31:0] word_t;

    // Fixed-point cosine weights (scaled by 2048*sqrt(2)).
    localparam int c_W1 = 2841;
    localparam int c_W2 = 2676;
    localparam int c_W3 = 2408;
    localparam int c_W5 = 1609;
    localparam int c_W6 = 1108;
    localparam int c_W7 = 565;

    // 181/256 ~ 1/sqrt(2), used for the odd-part butterfly.
    localparam int c_C181   = 181;
    // Rounding bias folded into X0 so the final >>>8 rounds to nearest.
    localparam int c_RND_X0 = 128;
    // Rounding bias for the 181/256 multiply.
    localparam int c_RND_M  = 128;

    // (181*a + 128) >>> 8 in 32-bit signed arithmetic.
    function automatic word_t mul181_rnd(input word_t a);
        return (word_t'(c_C181) * a + word_t'(c_RND_M)) >>> 8;
    endfunction

endpackage : idct_pkg
`default_nettype wire

// File: rtl/idct_sat.sv
`default_nettype none
// ============================================================================
// Module   : idct_sat
// Purpose  : Reduces one 32-bit signed IDCT sample to OUT_W bits, either by
//            clamping to the signed OUT_W range (SAT=1) or by keeping the low
//            OUT_W bits (SAT=0). Purely combinational.
// Ports    : i_y - 32-bit signed sample
//            o_y - OUT_W-bit result
// Revision : 1.0 - initial release
// ============================================================================
module idct_sat
    import idct_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int SAT   = 0
) (
    input  word_t              i_y,
    output logic [OUT_W-1:0]   o_y
);

    // Bounds held in 33 bits so OUT_W=32 does not overflow.
    localparam logic signed [32:0] c_MAX = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
    localparam logic signed [32:0] c_MIN = -(33'sd1 <<< (OUT_W - 1));

    logic signed [32:0] w_y33;
    logic               w_hi;
    logic               w_lo;

    assign w_y33 = {i_y[31], i_y};
    assign w_hi  = (w_y33 > c_MAX);
    assign w_lo  = (w_y33 < c_MIN);

    always_comb begin
        o_y = i_y[OUT_W-1:0];
        if (SAT != 0) begin
            if (w_hi)      o_y = c_MAX[OUT_W-1:0];
            else if (w_lo) o_y = c_MIN[OUT_W-1:0];
        end
    end

endmodule : idct_sat
`default_nettype wire

// File: rtl/idct8_row_pipe.sv
`default_nettype none
// ============================================================================
// Module   : idct8_row_pipe
// Purpose  : Pipelined 8-point row IDCT with valid/ready handshaking, DC
//            shortcut, optional output saturation and block-end marking.
//            Rank 0 registers the accepted row, ranks 1-3 hold the butterfly
//            stages, rank 4 is the output register (4 edges after accept).
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready/in_coef   - input row, lane k = b[k]
//            out_valid/out_ready/out_row - output row, lane k = y[k]
//            out_last - final row of a ROWS_PER_BLK block
//            out_dc   - row produced by the DC shortcut
// Revision : 1.0 - initial release
// ============================================================================
module idct8_row_pipe
    import idct_pkg::*;
#(
    parameter int IN_W         = 12,
    parameter int OUT_W        = 32,
    parameter int SAT          = 0,
    parameter int ROWS_PER_BLK = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    in_coef,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   out_row,
    output logic                 out_last,
    output logic                 out_dc
);

    localparam int RC_W = (ROWS_PER_BLK > 1) ? $clog2(ROWS_PER_BLK) : 1;

    logic w_adv;
    word_t w_bin [8];

    // Rank 0: sign-extended input row
    logic  r_v0;
    word_t r_b [8];
    // Rank 1: X terms
    logic  r_v1, r_dc1;
    word_t r_b0_1;
    word_t r_x [8];
    // Rank 2: first butterflies
    logic  r_v2, r_dc2;
    word_t r_b0_2, r_s01, r_d01, r_x2, r_x3, r_s46_2, r_s57_2, r_a, r_bb;
    // Rank 3: second butterflies
    logic  r_v3, r_dc3;
    word_t r_b0_3, r_p, r_q, r_r, r_t, r_m, r_n, r_s46_3, r_s57_3;
    // Rank 4: output
    logic               r_out_v, r_out_dc;
    logic [8*OUT_W-1:0] r_out_row;
    logic [RC_W-1:0]    r_rc;

    word_t w_t, w_u, w_v;
    word_t w_x [8];
    logic  w_dc1;
    word_t w_y [8];
    logic [OUT_W-1:0] w_sat [8];

    // The whole pipe moves together whenever the output slot can drain.
    assign w_adv    = !r_out_v || out_ready;
    assign in_ready = w_adv;

    generate
        for (genvar k = 0; k < 8; k++) begin : g_in
            assign w_bin[k] = {{(32-IN_W){in_coef[k*IN_W+IN_W-1]}},
                               in_coef[k*IN_W +: IN_W]};
        end
    endgenerate

    // Stage 1 arithmetic from the registered row
    always_comb begin
        w_t    = word_t'(c_W7) * (r_b[1] + r_b[7]);
        w_u    = word_t'(c_W3) * (r_b[5] + r_b[3]);
        w_v    = word_t'(c_W6) * (r_b[6] + r_b[2]);
        w_x[0] = (r_b[0] <<< 11) + word_t'(c_RND_X0);
        w_x[1] = r_b[4] <<< 11;
        w_x[2] = w_v - word_t'(c_W2 + c_W6) * r_b[6];
        w_x[3] = w_v + word_t'(c_W2 - c_W6) * r_b[2];
        w_x[4] = w_t + word_t'(c_W1 - c_W7) * r_b[1];
        w_x[5] = w_t - word_t'(c_W1 + c_W7) * r_b[7];
        w_x[6] = w_u - word_t'(c_W3 - c_W5) * r_b[5];
        w_x[7] = w_u - word_t'(c_W3 + c_W5) * r_b[3];
        w_dc1  = ((r_b[1] | r_b[2] | r_b[3] | r_b[4] |
                   r_b[5] | r_b[6] | r_b[7]) == '0);
    end

    // Stage 4 outputs; DC rows bypass the butterfly result.
    always_comb begin
        w_y[0] = (r_p + r_s46_3) >>> 8;
        w_y[1] = (r_r + r_m)     >>> 8;
        w_y[2] = (r_t + r_n)     >>> 8;
        w_y[3] = (r_q + r_s57_3) >>> 8;
        w_y[4] = (r_q - r_s57_3) >>> 8;
        w_y[5] = (r_t - r_n)     >>> 8;
        w_y[6] = (r_r - r_m)     >>> 8;
        w_y[7] = (r_p - r_s46_3) >>> 8;
        if (r_dc3) begin
            for (int k = 0; k < 8; k++) w_y[k] = r_b0_3 <<< 3;
        end
    end

    generate
        for (genvar k = 0; k < 8; k++) begin : g_lane
            idct_sat #(.OUT_W(OUT_W), .SAT(SAT)) u_sat (
                .i_y (w_y[k]),
                .o_y (w_sat[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v0 <= 1'b0;  r_v1 <= 1'b0;  r_v2 <= 1'b0;  r_v3 <= 1'b0;
            r_dc1 <= 1'b0; r_dc2 <= 1'b0; r_dc3 <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_b[k] <= '0;
                r_x[k] <= '0;
            end
            r_b0_1 <= '0; r_b0_2 <= '0; r_b0_3 <= '0;
            r_s01 <= '0; r_d01 <= '0; r_x2 <= '0; r_x3 <= '0;
            r_s46_2 <= '0; r_s57_2 <= '0; r_a <= '0; r_bb <= '0;
            r_p <= '0; r_q <= '0; r_r <= '0; r_t <= '0; r_m <= '0; r_n <= '0;
            r_s46_3 <= '0; r_s57_3 <= '0;
            r_out_v   <= 1'b0;
            r_out_dc  <= 1'b0;
            r_out_row <= '0;
        end else if (w_adv) begin
            // Rank 0
            r_v0 <= in_valid;
            for (int k = 0; k < 8; k++) r_b[k] <= w_bin[k];
            // Rank 1
            r_v1   <= r_v0;
            r_dc1  <= w_dc1;
            r_b0_1 <= r_b[0];
            for (int k = 0; k < 8; k++) r_x[k] <= w_x[k];
            // Rank 2
            r_v2    <= r_v1;
            r_dc2   <= r_dc1;
            r_b0_2  <= r_b0_1;
            r_s01   <= r_x[0] + r_x[1];
            r_d01   <= r_x[0] - r_x[1];
            r_x2    <= r_x[2];
            r_x3    <= r_x[3];
            r_s46_2 <= r_x[4] + r_x[6];
            r_s57_2 <= r_x[5] + r_x[7];
            r_a     <= (r_x[4] - r_x[6]) + (r_x[5] - r_x[7]);
            r_bb    <= (r_x[4] - r_x[6]) - (r_x[5] - r_x[7]);
            // Rank 3
            r_v3    <= r_v2;
            r_dc3   <= r_dc2;
            r_b0_3  <= r_b0_2;
            r_p     <= r_s01 + r_x3;
            r_q     <= r_s01 - r_x3;
            r_r     <= r_d01 + r_x2;
            r_t     <= r_d01 - r_x2;
            r_m     <= mul181_rnd(r_a);
            r_n     <= mul181_rnd(r_bb);
            r_s46_3 <= r_s46_2;
            r_s57_3 <= r_s57_2;
            // Rank 4
            r_out_v  <= r_v3;
            r_out_dc <= r_v3 && r_dc3;
            for (int k = 0; k < 8; k++) r_out_row[k*OUT_W +: OUT_W] <= w_sat[k];
        end
    end

    // Row-in-block counter advances on each output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rc <= '0;
        end else if (r_out_v && out_ready) begin
            if (r_rc == RC_W'(ROWS_PER_BLK - 1)) r_rc <= '0;
            else                                  r_rc <= r_rc + 1'b1;
        end
    end

    assign out_valid = r_out_v;
    assign out_dc    = r_out_dc;
    assign out_row   = r_out_row;
    assign out_last  = r_out_v && (r_rc == RC_W'(ROWS_PER_BLK - 1));

endmodule : idct8_row_pipe
`default_nettype wire

// File: tb/tb_idct8_row_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_idct8_row_pipe
// Purpose  : Self-checking bench for idct8_row_pipe. Two instances run side by
//            side: the default configuration and a SAT=1, OUT_W=9 variant.
//            Expected rows come from an arithmetic reference of the IDCT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idct8_row_pipe;

    typedef struct packed {
        logic [255:0] row;   // eight 32-bit lanes, low OUT_W bits significant
        logic         dc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    // default instance
    logic         in_valid, in_ready, out_valid, out_ready, out_last, out_dc;
    logic [95:0]  in_coef;
    logic [255:0] out_row;
    // saturating 9-bit instance
    logic         in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_last_s, out_dc_s;
    logic [95:0]  in_coef_s;
    logic [71:0]  out_row_s;

    int n_chk = 0;
    int n_err = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   emit0 = 0;
    int   emit1 = 0;

    always #5 clk = ~clk;

    idct8_row_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_last(out_last), .out_dc(out_dc)
    );

    idct8_row_pipe #(.IN_W(12), .OUT_W(9), .SAT(1), .ROWS_PER_BLK(8)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_coef(in_coef_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_row(out_row_s),
        .out_last(out_last_s), .out_dc(out_dc_s)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference IDCT computed straight from the arithmetic definition.
    function automatic exp_t ref_row(input logic [95:0] c, input int ow, input bit sat);
        exp_t   r;
        int     b[8];
        int     y[8];
        int     x0, x1, x2, x3, x4, x5, x6, x7, t, u, v;
        int     s01, d01, s46, d46, s57, d57, a, bb, p, q, rr, tt, m, n;
        longint lv, lmax, lmin;
        for (int k = 0; k < 8; k++) b[k] = int'($signed(c[k*12 +: 12]));
        r.dc = (b[1] == 0) && (b[2] == 0) && (b[3] == 0) && (b[4] == 0) &&
               (b[5] == 0) && (b[6] == 0) && (b[7] == 0);
        x0 = (b[0] * 2048) + 128;  x1 = b[4] * 2048;
        t = 565 * (b[1] + b[7]);   x4 = t + (2841 - 565) * b[1];  x5 = t - (2841 + 565) * b[7];
        u = 2408 * (b[5] + b[3]);  x6 = u - (2408 - 1609) * b[5]; x7 = u - (2408 + 1609) * b[3];
        v = 1108 * (b[6] + b[2]);  x2 = v - (2676 + 1108) * b[6]; x3 = v + (2676 - 1108) * b[2];
        s01 = x0 + x1; d01 = x0 - x1;
        s46 = x4 + x6; d46 = x4 - x6; s57 = x5 + x7; d57 = x5 - x7;
        a = d46 + d57; bb = d46 - d57;
        p = s01 + x3; q = s01 - x3; rr = d01 + x2; tt = d01 - x2;
        m = (181 * a + 128) >>> 8; n = (181 * bb + 128) >>> 8;
        y[0] = (p + s46) >>> 8;  y[1] = (rr + m) >>> 8;
        y[2] = (tt + n) >>> 8;   y[3] = (q + s57) >>> 8;
        y[4] = (q - s57) >>> 8;  y[5] = (tt - n) >>> 8;
        y[6] = (rr - m) >>> 8;   y[7] = (p - s46) >>> 8;
        lmax = (64'sd1 <<< (ow - 1)) - 1;
        lmin = -(64'sd1 <<< (ow - 1));
        for (int k = 0; k < 8; k++) begin
            lv = r.dc ? longint'(b[0]) * 8 : longint'(y[k]);
            if (sat && lv > lmax) lv = lmax;
            if (sat && lv < lmin) lv = lmin;
            r.row[k*32 +: 32] = 32'(lv);
        end
        return r;
    endfunction

    function automatic logic [71:0] pack9(input logic [255:0] r);
        logic [71:0] p;
        for (int k = 0; k < 8; k++) p[k*9 +: 9] = r[k*32 +: 9];
        return p;
    endfunction

    function automatic logic [95:0] rand_coef();
        logic [95:0] c;
        for (int k = 0; k < 8; k++) c[k*12 +: 12] = 12'($urandom);
        if ($urandom_range(0, 3) == 0) c[95:12] = '0;
        return c;
    endfunction

    // One clock: inputs are already set; check handshakes before the edge,
    // update the scoreboards after it, and return 1 time unit past the edge.
    task automatic tick();
        bit   hs_in0, hs_out0, hs_in1, hs_out1;
        exp_t e, n0, n1;
        #1;
        chk("in_ready", in_ready, !out_valid || out_ready);
        chk("in_ready_s", in_ready_s, !out_valid_s || out_ready_s);
        hs_in0  = in_valid && in_ready;
        hs_out0 = out_valid && out_ready;
        hs_in1  = in_valid_s && in_ready_s;
        hs_out1 = out_valid_s && out_ready_s;
        n0 = ref_row(in_coef, 32, 1'b0);
        n1 = ref_row(in_coef_s, 9, 1'b1);
        if (hs_out0) begin
            chk("row_expected", 1'b1, q0.size() != 0);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("out_row", out_row, e.row);
                chk("out_dc", out_dc, e.dc);
                chk("out_last", out_last, (emit0 % 8) == 7);
                emit0++;
            end
        end
        if (hs_out1) begin
            chk("row_expected_s", 1'b1, q1.size() != 0);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("out_row_s", out_row_s, pack9(e.row));
                chk("out_dc_s", out_dc_s, e.dc);
                chk("out_last_s", out_last_s, (emit1 % 8) == 7);
                emit1++;
            end
        end
        @(posedge clk);
        #1;
        if (hs_in0) q0.push_back(n0);
        if (hs_in1) q1.push_back(n1);
    endtask

    task automatic drain();
        in_valid = 1'b0; in_valid_s = 1'b0;
        out_ready = 1'b1; out_ready_s = 1'b1;
        for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) tick();
        chk("drain_done", (q0.size() == 0) && (q1.size() == 0), 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; in_coef = '0;
        in_valid_s = 1'b0; out_ready_s = 1'b1; in_coef_s = '0;
        #1;
        // Reset state
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_row", out_row, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_dc", out_dc, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_in_ready_held", in_ready, 1'b1);
        reset = 1'b0;
        chk("in_ready_after_rst", in_ready, 1'b1);

        // DC row b0=5 with latency check; saturating instance gets b0=2047
        in_coef = 96'd5; in_valid = 1'b1;
        in_coef_s = 96'd2047; in_valid_s = 1'b1;
        tick();
        in_valid = 1'b0; in_valid_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lat_not_yet", out_valid, 1'b0);
        end
        tick();
        chk("lat_valid", out_valid, 1'b1);
        chk("dc_row", out_row, {8{32'd40}});
        chk("dc_flag", out_dc, 1'b1);
        chk("sat_pos", out_row_s, {8{9'h0FF}});
        chk("sat_pos_dc", out_dc_s, 1'b1);
        tick();

        // b4=1 impulse; saturating instance gets b0=-2048
        in_coef = 96'd1 << 48; in_valid = 1'b1;
        in_coef_s = 96'h800; in_valid_s = 1'b1;
        tick();
        in_valid = 1'b0; in_valid_s = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("b4_valid", out_valid, 1'b1);
        chk("b4_row", out_row, {32'sd8, -32'sd8, -32'sd8, 32'sd8,
                                32'sd8, -32'sd8, -32'sd8, 32'sd8});
        chk("b4_dc", out_dc, 1'b0);
        chk("sat_neg", out_row_s, {8{9'h100}});
        drain();

        // Reset with three rows in flight
        in_valid = 1'b1; in_valid_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_coef = rand_coef(); in_coef_s = rand_coef();
            tick();
        end
        in_valid = 1'b0; in_valid_s = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_row", out_row, '0);
        chk("mid_rst_last", out_last, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        q0.delete(); q1.delete(); emit0 = 0; emit1 = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_ghost_row", out_valid, 1'b0);
        end

        // Block framing: 16 back-to-back rows, counter starts from 0
        in_valid = 1'b1; in_valid_s = 1'b1;
        out_ready = 1'b1; out_ready_s = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_coef = rand_coef(); in_coef_s = rand_coef();
            tick();
        end
        drain();
        chk("frame_rows", emit0, 16);

        // Backpressure: fill with out_ready low, hold 3 cycles, then drain
        out_ready = 1'b0; out_ready_s = 1'b0;
        in_valid = 1'b1; in_valid_s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_coef = rand_coef(); in_coef_s = rand_coef();
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_hold_row", out_row, q0[0].row);
            chk("bp_hold_dc", out_dc, q0[0].dc);
        end
        chk("bp_rows_held", q0.size(), 5);
        drain();
        chk("bp_rows_out", emit0, 21);

        // Randomised traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_valid_s  = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            out_ready_s = ($urandom_range(0, 2) != 0);
            in_coef     = rand_coef();
            in_coef_s   = rand_coef();
            tick();
        end
        drain();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_no_extra", out_valid || out_valid_s, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_idct8_row_pipe
`default_nettype wire

// File: doc/idct8_row_pipe.md
IDCT8_ROW_PIPE -- requirements
Module: idct8_row_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 12: signed width of each input coefficient.
REQ-002 SHALL have parameter OUT_W, default 32: signed width of each output sample.
REQ-003 SHALL have parameter SAT, default 0: 1 = clamp outputs to the signed OUT_W range, 0 = truncate to the low OUT_W bits.
REQ-004 SHALL have parameter ROWS_PER_BLK, default 8: rows per block, used for out_last.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  in_coef holds a valid row.
- in_ready  out  1  block accepts a row this cycle.
- in_coef  in  8*IN_W  lane k = coefficient b[k], natural order, lane 0 in the LSBs.
- out_valid  out  1  out_row is valid.
- out_ready  in  1  downstream accepts the row.
- out_row  out  8*OUT_W  lane k = y[k].
- out_last  out  1  marks the final row of a block.
- out_dc  out  1  row was produced by the DC shortcut.

Function
REQ-006 SHALL accept a row on a rising edge when in_valid && in_ready.
REQ-007 SHALL emit a row on a rising edge when out_valid && out_ready.
REQ-008 SHALL be a 4-stage pipeline with a global advance signal adv = !out_valid || out_ready.
REQ-009 SHALL drive in_ready = adv combinationally and shift every stage only when adv=1.
REQ-010 SHALL latch out_row in the 4th cycle after acceptance when never stalled, so out_valid rises at the 4th edge after the accepting edge.
REQ-011 SHALL sustain one row per cycle while out_ready=1.
REQ-012 SHALL hold out_row, out_last and out_dc stable, and never drop or duplicate a row, while out_valid && !out_ready.
REQ-013 SHALL let empty stages (valid bit 0) advance freely (bubble collapse is not required).
REQ-014 SHALL sign-extend inputs and compute internally in 32-bit signed arithmetic, with >>> as the arithmetic right shift.
REQ-015 SHALL use constants W1=2841, W2=2676, W3=2408, W5=1609, W6=1108, W7=565.
REQ-016 SHALL compute stage 1 as:
- X0=(b0<<11)+128; X1=b4<<11.
- t=W7*(b1+b7); X4=t+(W1-W7)*b1; X5=t-(W1+W7)*b7.
- u=W3*(b5+b3); X6=u-(W3-W5)*b5; X7=u-(W3+W5)*b3.
- v=W6*(b6+b2); X2=v-(W2+W6)*b6; X3=v+(W2-W6)*b2.
REQ-017 SHALL compute stage 2 as:
- S01=X0+X1; D01=X0-X1.
- S46=X4+X6; D46=X4-X6; S57=X5+X7; D57=X5-X7.
- A=D46+D57; B=D46-D57.
REQ-018 SHALL compute stage 3 as:
- P=S01+X3; Q=S01-X3; R=D01+X2; T=D01-X2.
- M=(181*A+128)>>>8; N=(181*B+128)>>>8.
REQ-019 SHALL compute stage 4 as:
- y0=(P+S46)>>>8; y1=(R+M)>>>8; y2=(T+N)>>>8; y3=(Q+S57)>>>8.
- y4=(Q-S57)>>>8; y5=(T-N)>>>8; y6=(R-M)>>>8; y7=(P-S46)>>>8.
REQ-020 SHALL use the DC shortcut when b1..b7 are all zero: all eight y = b0<<3 and out_dc=1; the DC flag travels with the row through the pipeline.
REQ-021 SHALL, when SAT=1, clamp each y to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
REQ-022 SHALL, when SAT=0, take the low OUT_W bits of each y.
REQ-023 SHALL keep row counter rc (width $clog2(ROWS_PER_BLK)), incremented on each output handshake and wrapping from ROWS_PER_BLK-1 to 0.
REQ-024 SHALL drive out_last = out_valid && rc==ROWS_PER_BLK-1.
REQ-025 SHALL handle a simultaneous accept and emit in the same cycle with no loss.

Reset
REQ-026 SHALL, on reset assertion, immediately clear all stage valid bits, out_valid, out_last, out_dc, out_row (to 0) and rc (to 0).
REQ-027 SHALL discard rows in flight at reset; none are emitted afterwards.
REQ-028 SHALL have in_ready=1 while reset is held and after release.

Structure
REQ-029 SHALL take W1..W7, the value 181 and the rounding constants from shared package idct_pkg, so the column pass reuses them.
REQ-030 SHALL instantiate sub-module idct_sat (one per lane) for the OUT_W clamp/truncate.

Verification
REQ-031 SHALL cover DC only: b0=5, others 0 -> 4 edges later all y=40, out_dc=1.
REQ-032 SHALL cover b4=1, others 0 -> y=[8,-8,-8,8,8,-8,-8,8], out_dc=0.
REQ-033 SHALL cover backpressure: pipe full, out_ready=0 for 3 cycles -> in_ready=0, out_row unchanged, then all rows emitted in order exactly once.
REQ-034 SHALL cover block framing: 16 back-to-back rows with out_ready=1 -> out_last high on output rows 8 and 16 only.
REQ-035 SHALL cover reset mid-stream: reset with 3 rows in flight -> out_valid=0 immediately, those rows never emitted, rc=0.
REQ-036 SHALL cover saturation: SAT=1, OUT_W=9, DC b0=2047 -> all y=255; b0=-2048 -> all y=-256.
